// File: rtl/mr_wb_uart_tx_if.sv
// Pipelined Wishbone B4 bundle between the bus arbiter (master) and the UART TX slave.
// A request is accepted on any cycle with cyc_i & stb_i. ack_o or err_o follows one cycle
// later with dat_o, and only while cyc_i is still high. stall_o is never asserted.
interface mr_wb_uart_tx_if #(
  parameter int ADDR_BITS = 30,
  parameter int XLEN      = 32
);
  logic [ADDR_BITS-1:0] addr_i;
  logic                 we_i;
  logic [XLEN/8-1:0]    sel_i;
  logic [XLEN-1:0]      dat_i;
  logic                 stb_i;
  logic                 cyc_i;
  logic                 ack_o;
  logic                 err_o;
  logic [XLEN-1:0]      dat_o;
  logic                 stall_o;

  modport master (
    output addr_i, we_i, sel_i, dat_i, stb_i, cyc_i,
    input  ack_o, err_o, dat_o, stall_o
  );

  modport slave (
    input  addr_i, we_i, sel_i, dat_i, stb_i, cyc_i,
    output ack_o, err_o, dat_o, stall_o
  );
endinterface

// File: rtl/mr_wb_uart_tx.sv
// Wishbone UART transmitter: byte FIFO feeding an 8N1 LSB-first serialiser whose
// bit time is DIVISOR clocks. DIVISOR is latched at each START.
module mr_wb_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 868,
  parameter int ADDR_BITS  = 30,
  parameter int XLEN       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mr_wb_uart_tx_if.slave   bus,
  output logic             tx_o,
  output logic [1:0]       state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW    = PTR_W - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, level;
  logic             full, empty, push, pop, div_we;
  logic [15:0]      divisor, frame_div, timer;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic             tx_q;
  logic             req, rsp_err, ack_q, err_q;
  logic [XLEN-1:0]  rsp_dat, dat_q;
  logic [7:0]       status;
  logic [3:0]       level4;
  logic             unused_bits;

  assign unused_bits = ^{bus.addr_i[ADDR_BITS-1:2], bus.sel_i[XLEN/8-1:2], bus.dat_i[XLEN-1:16]};

  // Full/empty/level come from pre-cycle pointers, so a pop in the same cycle never frees a slot.
  assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign level  = wr_ptr - rd_ptr;
  assign level4 = 4'(level);
  assign status = {level4, 1'b0, (state != IDLE), empty, full};
  assign req    = bus.cyc_i & bus.stb_i;

  always_comb begin
    push    = 1'b0;
    div_we  = 1'b0;
    rsp_err = 1'b0;
    rsp_dat = '0;
    if (req) begin
      case (bus.addr_i[1:0])
        2'd0: begin
          if (bus.we_i && bus.sel_i[0]) begin
            if (full) rsp_err = 1'b1;
            else      push    = 1'b1;
          end
        end
        2'd1: begin
          if (bus.we_i) rsp_err = 1'b1;
          else          rsp_dat = XLEN'(status);
        end
        2'd2: begin
          if (bus.we_i) div_we  = (bus.sel_i[1:0] == 2'b11);
          else          rsp_dat = XLEN'(divisor);
        end
        default: rsp_err = 1'b1;
      endcase
    end
  end

  assign pop = !empty && ((state == IDLE) || (state == STOP && timer == 16'd0));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      divisor <= 16'(DIV_RESET);
    end else begin
      ack_q <= req & ~rsp_err;
      err_q <= req & rsp_err;
      dat_q <= (req & ~rsp_err) ? rsp_dat : '0;
      if (div_we) divisor <= (bus.dat_i[15:0] == 16'd0) ? 16'd1 : bus.dat_i[15:0];
    end
  end

  // A response whose cycle was dropped by the master is swallowed.
  assign bus.ack_o   = ack_q & bus.cyc_i;
  assign bus.err_o   = err_q & bus.cyc_i;
  assign bus.dat_o   = dat_q;
  assign bus.stall_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.dat_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= IDLE;
      tx_q      <= 1'b1;
      timer     <= '0;
      frame_div <= 16'd1;
      shift     <= '0;
      bit_idx   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (!empty) begin
            shift     <= mem[rd_ptr[AW-1:0]];
            frame_div <= divisor;
            timer     <= divisor - 16'd1;
            tx_q      <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (timer != 16'd0) timer <= timer - 16'd1;
          else begin
            timer   <= frame_div - 16'd1;
            tx_q    <= shift[0];
            bit_idx <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (timer != 16'd0) timer <= timer - 16'd1;
          else begin
            timer <= frame_div - 16'd1;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx_q    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (timer != 16'd0) timer <= timer - 16'd1;
          else if (!empty) begin
            // Next frame starts with no idle gap.
            shift     <= mem[rd_ptr[AW-1:0]];
            frame_div <= divisor;
            timer     <= divisor - 16'd1;
            tx_q      <= 1'b0;
            state     <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_o      = tx_q;
  assign state_dbg = state;
endmodule

// File: tb/tb_mr_wb_uart_tx.sv
// Directed bench for mr_wb_uart_tx: register map, error responses, serial framing,
// FIFO full behaviour, mid-frame divisor change and mid-frame reset.
module tb_mr_wb_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx;
  logic [1:0]  state_dbg;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        rec_en = 1'b0;
  logic        tx_log[$];
  logic [0:0]  exp_q[$];

  always #5 clk = ~clk;

  mr_wb_uart_tx_if wb ();

  mr_wb_uart_tx dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .bus       (wb),
    .tx_o      (tx),
    .state_dbg (state_dbg)
  );

  always @(negedge clk) if (rec_en) tx_log.push_back(tx);

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [1:0] off, input logic we, input logic [3:0] sel,
                      input logic [31:0] wd, output logic ack, output logic err,
                      output logic [31:0] rd);
    @(posedge clk); #1;
    wb.addr_i = {28'h0, off};
    wb.we_i   = we;
    wb.sel_i  = sel;
    wb.dat_i  = wd;
    wb.cyc_i  = 1'b1;
    wb.stb_i  = 1'b1;
    @(posedge clk); #1;
    wb.stb_i = 1'b0;
    ack = wb.ack_o;
    err = wb.err_o;
    rd  = wb.dat_o;
    wb.cyc_i = 1'b0;
    wb.we_i  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic a, e;
    logic [31:0] d;
    xfer(off, 1'b0, 4'hF, 32'h0, a, e, d);
    check32({tag, "_ackerr"}, {30'h0, a, e}, 32'h2);
    check32({tag, "_dat"}, d, exp);
  endtask

  task automatic wr_chk(input string tag, input logic [1:0] off, input logic [3:0] sel,
                        input logic [31:0] wd, input logic exp_ack, input logic exp_err);
    logic a, e;
    logic [31:0] d;
    xfer(off, 1'b1, sel, wd, a, e, d);
    check32({tag, "_ackerr"}, {30'h0, a, e}, {30'h0, exp_ack, exp_err});
  endtask

  task automatic exp_frame(input logic [7:0] b, input int div);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < div; j++) exp_q.push_back(bits[i]);
  endtask

  // Compares the recorded line against exp_q, starting at the first low sample;
  // everything before and after the expected stream must be idle high.
  task automatic check_stream(input string tag, input int exp_first);
    int first, mism;
    first = -1;
    mism  = 0;
    for (int i = 0; i < tx_log.size(); i++)
      if (first < 0 && tx_log[i] == 1'b0) first = i;
    if (first < 0 || first + exp_q.size() > tx_log.size()) mism = 1;
    else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (tx_log[first + i] !== exp_q[i][0]) mism++;
      for (int i = first + exp_q.size(); i < tx_log.size(); i++)
        if (tx_log[i] !== 1'b1) mism++;
    end
    check32({tag, "_bits"}, mism, 0);
    if (exp_first >= 0) check32({tag, "_latency"}, first, exp_first);
    exp_q.delete();
    tx_log.delete();
  endtask

  logic [7:0] bytes [10] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h96, 8'h7E};
  logic [9:0] ack_v, err_v;
  int         zeros;

  initial begin
    wb.addr_i = '0; wb.we_i = 1'b0; wb.sel_i = '0; wb.dat_i = '0;
    wb.stb_i = 1'b0; wb.cyc_i = 1'b0;

    // Reset state
    step(3);
    check32("rst_tx", {31'h0, tx}, 32'h1);
    check32("rst_ackerr", {30'h0, wb.ack_o, wb.err_o}, 32'h0);
    check32("rst_dat", wb.dat_o, 32'h0);
    check32("rst_state", {30'h0, state_dbg}, 32'h0);
    rst_n = 1'b1;
    rd_chk("rst_status", 2'd1, 32'h2);
    rd_chk("rst_div", 2'd2, 32'd868);
    rd_chk("rd_txdata", 2'd0, 32'h0);

    // Single frame, DIVISOR=4; first START sample one cycle after the push
    wr_chk("wr_div4", 2'd2, 4'hF, 32'd4, 1'b1, 1'b0);
    xfer(2'd0, 1'b1, 4'h1, 32'hA5, ack_v[0], err_v[0], wb.dat_i);
    check32("wr_a5_ackerr", {30'h0, ack_v[0], err_v[0]}, 32'h2);
    rec_en = 1'b1;
    step(50);
    rec_en = 1'b0;
    exp_frame(8'hA5, 4);
    check_stream("frame_a5", 1);

    // Error responses leave state untouched
    wr_chk("rd_off3", 2'd3, 4'hF, 32'h0, 1'b0, 1'b1);
    begin
      logic a, e;
      logic [31:0] d;
      xfer(2'd3, 1'b0, 4'hF, 32'h0, a, e, d);
      check32("rd_off3_ackerr", {30'h0, a, e}, 32'h1);
    end
    wr_chk("wr_status", 2'd1, 4'hF, 32'hFF, 1'b0, 1'b1);
    rd_chk("err_status", 2'd1, 32'h2);
    rd_chk("err_div", 2'd2, 32'd4);

    // Lane-0-clear writes are acked with no effect
    wr_chk("wr_tx_nolane0", 2'd0, 4'hE, 32'h55, 1'b1, 1'b0);
    rd_chk("nolane0_status", 2'd1, 32'h2);
    wr_chk("wr_div_lane0", 2'd2, 4'h1, 32'd9, 1'b1, 1'b0);
    rd_chk("div_partial", 2'd2, 32'd4);

    // DIVISOR=2, ten pipelined byte writes: one pops at once, eight fill the FIFO, tenth errors
    wr_chk("wr_div2", 2'd2, 4'hF, 32'd2, 1'b1, 1'b0);
    rec_en = 1'b1;
    @(posedge clk); #1;
    wb.cyc_i = 1'b1; wb.we_i = 1'b1; wb.sel_i = 4'h1; wb.addr_i = '0;
    for (int k = 0; k < 10; k++) begin
      wb.stb_i = 1'b1;
      wb.dat_i = {24'h0, bytes[k]};
      @(posedge clk); #1;
      ack_v[k] = wb.ack_o;
      err_v[k] = wb.err_o;
    end
    wb.stb_i = 1'b0; wb.cyc_i = 1'b0; wb.we_i = 1'b0;
    check32("burst_ack", {22'h0, ack_v}, 32'h1FF);
    check32("burst_err", {22'h0, err_v}, 32'h200);
    rd_chk("burst_status_full", 2'd1, 32'h85);
    step(200);
    rec_en = 1'b0;
    for (int k = 0; k < 9; k++) exp_frame(bytes[k], 2);
    check_stream("burst_frames", -1);
    rd_chk("burst_status_end", 2'd1, 32'h2);

    // DIVISOR=0 stored as 1: ten-cycle frame
    wr_chk("wr_div0", 2'd2, 4'h3, 32'd0, 1'b1, 1'b0);
    rd_chk("div0_read", 2'd2, 32'd1);
    rec_en = 1'b1;
    wr_chk("wr_3c", 2'd0, 4'h1, 32'h3C, 1'b1, 1'b0);
    step(15);
    rec_en = 1'b0;
    exp_frame(8'h3C, 1);
    check_stream("frame_div1", -1);

    // DIVISOR change mid-frame applies to the next frame only
    wr_chk("wr_div4b", 2'd2, 4'hF, 32'd4, 1'b1, 1'b0);
    rec_en = 1'b1;
    wr_chk("wr_5a", 2'd0, 4'h1, 32'h5A, 1'b1, 1'b0);
    step(10);
    wr_chk("wr_div8_mid", 2'd2, 4'hF, 32'd8, 1'b1, 1'b0);
    step(40);
    rec_en = 1'b0;
    exp_frame(8'h5A, 4);
    check_stream("frame_mid_div", -1);
    rd_chk("div8_read", 2'd2, 32'd8);
    rec_en = 1'b1;
    wr_chk("wr_f0", 2'd0, 4'h1, 32'hF0, 1'b1, 1'b0);
    step(90);
    rec_en = 1'b0;
    exp_frame(8'hF0, 8);
    check_stream("frame_div8", -1);

    // Reset during DATA bit 3 of a 0x00 frame, with a second byte still queued
    wr_chk("wr_div4c", 2'd2, 4'hF, 32'd4, 1'b1, 1'b0);
    wr_chk("wr_00", 2'd0, 4'h1, 32'h00, 1'b1, 1'b0);
    wr_chk("wr_81", 2'd0, 4'h1, 32'h81, 1'b1, 1'b0);
    step(16);
    check32("pre_rst_state", {30'h0, state_dbg}, 32'h2);
    check32("pre_rst_tx", {31'h0, tx}, 32'h0);
    rst_n = 1'b0;
    step(1);
    check32("mid_rst_tx", {31'h0, tx}, 32'h1);
    check32("mid_rst_state", {30'h0, state_dbg}, 32'h0);
    rst_n = 1'b1;
    rec_en = 1'b1;
    step(20);
    rec_en = 1'b0;
    zeros = 0;
    foreach (tx_log[i]) if (tx_log[i] !== 1'b1) zeros++;
    tx_log.delete();
    check32("post_rst_idle", zeros, 0);
    rd_chk("post_rst_status", 2'd1, 32'h2);
    rd_chk("post_rst_div", 2'd2, 32'd868);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
